issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; decoded-instruction handshake from decode stage.
REQ-004 SHALL have ports: ra_a, ra_b, ra_m, ra_d  in  4 each  decoded register addresses, 0 = unused/zero register.
REQ-005 SHALL have ports: is_mem  in  1  instruction is a memory op.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_ra_a, out_ra_b, out_ra_m, out_ra_d  out  4 each; out_is_mem  out  1; registered issue slot to execute.
REQ-007 SHALL have ports: wb_valid  in  1; wb_addr  in  4  register writeback completion.
REQ-008 SHALL have ports: mem_done  in  1  single-cycle pulse, outstanding memory op complete.
REQ-009 SHALL have ports: flush  in  1  kill the instruction held in the issue slot.
REQ-010 SHALL have ports: stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-011 SHALL keep scoreboard pending[15:1], one bit per register; register 0 never pending, never hazards.
REQ-012 SHALL keep mem_busy, 1 bit, set while one memory op is outstanding; max one outstanding.
REQ-013 SHALL implement issue-slot FSM EMPTY/FULL: EMPTY->FULL on accept; FULL->EMPTY on out_valid&&out_ready without accept; FULL->FULL on simultaneous drain+accept; any->EMPTY on flush.
REQ-014 SHALL define wb_clr = wb_valid && wb_addr!=0, clearing pending[wb_addr] at the edge.
REQ-015 SHALL define hazard = any nonzero of ra_a/ra_b/ra_m/ra_d with pending bit set and not cleared by wb_clr this cycle, OR (is_mem && mem_busy && !mem_done).
REQ-016 SHALL drive in_ready = (EMPTY || out_ready) && !hazard && !flush, combinationally; accept = in_valid && in_ready.
REQ-017 SHALL on accept latch all ra_* and is_mem into slot, set pending[ra_d] if ra_d!=0, set mem_busy if is_mem; zero-cycle latency beyond the one register.
REQ-018 SHALL give set priority over clear when accept sets and wb_clr clears the same register in one cycle (result: pending=1).
REQ-019 SHALL clear mem_busy on mem_done; if accept of is_mem coincides with mem_done, mem_busy stays 1.
REQ-020 SHALL on flush while FULL and not draining: clear pending[out_ra_d] (if nonzero) and clear mem_busy if out_is_mem; no accept that cycle.
REQ-021 SHALL on flush coinciding with out_valid&&out_ready treat the slot as issued (no scoreboard rollback).
REQ-022 SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 SHALL increment stall_cnt each cycle in_valid && hazard && !flush, saturating at 16'hFFFF.
REQ-024 SHALL ignore wb_clr for registers not pending (no error, no state change).

Reset
REQ-025 SHALL on rst_n low, immediately and regardless of clk: FSM EMPTY, out_valid=0, out_ra_*=0, out_is_mem=0, pending=0, mem_busy=0, stall_cnt=0.
REQ-026 SHALL drop any in-flight slot contents and scoreboard on reset mid-operation; in_ready follows REQ-016 with reset state (1 if !flush).

Verification
REQ-027 SHALL pass: accept ra_d=3, then next instr ra_a=3 -> in_ready=0, stall_cnt increments; wb_valid wb_addr=3 -> in_ready=1 same cycle, accept.
REQ-028 SHALL pass: is_mem accepted, second is_mem presented -> stalled until mem_done pulse; accepted in the mem_done cycle, mem_busy remains 1.
REQ-029 SHALL pass: accept ra_d=5 while wb_valid wb_addr=5 same cycle -> pending[5]=1 afterward.
REQ-030 SHALL pass: slot FULL with out_ra_d=7, out_ready=0, flush=1 -> out_valid=0, pending[7]=0, in_ready=0 that cycle.
REQ-031 SHALL pass: ra_d=0 and ra_a=0 stream with out_ready=1 -> one accept per cycle, no stalls, pending stays 0.
REQ-032 SHALL pass: rst_n asserted mid-stall with pending[2]=1, mem_busy=1, stall_cnt=9 -> all zero asynchronously, out_valid=0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller: a single registered issue slot in front of execute,
// guarded by a per-register pending scoreboard and a one-deep memory-op
// tracker. An instruction is held back while any register it names is still
// pending, or while it is a memory op and another memory op is outstanding.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until ready is seen.
// in_ready is combinational and depends only on present inputs and state.
// out_valid and out_* are registered, and they stay stable while out_ready is low.
module issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  ra_a,
  input  logic [3:0]  ra_b,
  input  logic [3:0]  ra_m,
  input  logic [3:0]  ra_d,
  input  logic        is_mem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_ra_a,
  output logic [3:0]  out_ra_b,
  output logic [3:0]  out_ra_m,
  output logic [3:0]  out_ra_d,
  output logic        out_is_mem,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic        mem_done,
  input  logic        flush,
  output logic [15:0] stall_cnt,
  output logic        dbg_state,
  output logic [15:0] dbg_pending,
  output logic        dbg_mem_busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e state_q;
  logic        out_valid_q;
  logic [3:0]  out_ra_a_q, out_ra_b_q, out_ra_m_q, out_ra_d_q;
  logic        out_is_mem_q;
  logic [15:0] pending_q, pending_d;   // bit 0 is tied to zero
  logic        mem_busy_q, mem_busy_d;
  logic [15:0] stall_cnt_q;

  logic        wb_clr;
  logic [15:0] clr_mask;
  logic [15:0] live_pending;
  logic        reg_hazard;
  logic        hazard;
  logic        accept;
  logic        drain;
  logic        rollback;

  // Hazard detection: a writeback landing this cycle already frees its register.
  always_comb begin
    wb_clr       = wb_valid && (wb_addr != 4'd0);
    clr_mask     = wb_clr ? (16'h0001 << wb_addr) : 16'h0000;
    live_pending = pending_q & ~clr_mask;
    reg_hazard   = live_pending[ra_a] || live_pending[ra_b] ||
                   live_pending[ra_m] || live_pending[ra_d];
    hazard       = reg_hazard || (is_mem && mem_busy_q && !mem_done);
    in_ready     = ((state_q == EMPTY) || out_ready) && !hazard && !flush;
    accept       = in_valid && in_ready;
    drain        = out_valid_q && out_ready;
    // A flushed slot that was not issued gives back its scoreboard claims.
    rollback     = flush && (state_q == FULL) && !drain;
  end

  // Scoreboard next state: clears first, then an accept's set wins.
  always_comb begin
    pending_d = pending_q & ~clr_mask;
    if (rollback) begin
      pending_d = pending_d & ~(16'h0001 << out_ra_d_q);
    end
    if (accept && (ra_d != 4'd0)) begin
      pending_d = pending_d | (16'h0001 << ra_d);
    end
    pending_d[0] = 1'b0;

    mem_busy_d = mem_busy_q;
    if (mem_done) begin
      mem_busy_d = 1'b0;
    end
    if (rollback && out_is_mem_q) begin
      mem_busy_d = 1'b0;
    end
    if (accept && is_mem) begin
      mem_busy_d = 1'b1;
    end
  end

  // Issue-slot FSM with registered slot outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      out_ra_a_q   <= 4'd0;
      out_ra_b_q   <= 4'd0;
      out_ra_m_q   <= 4'd0;
      out_ra_d_q   <= 4'd0;
      out_is_mem_q <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state_q      <= FULL;
      out_valid_q  <= 1'b1;
      out_ra_a_q   <= ra_a;
      out_ra_b_q   <= ra_b;
      out_ra_m_q   <= ra_m;
      out_ra_d_q   <= ra_d;
      out_is_mem_q <= is_mem;
    end else if (drain) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
    end
  end

  // Scoreboard and memory-busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 16'h0000;
      mem_busy_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  // Saturating count of cycles a valid instruction is held by a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (in_valid && hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_ra_a     = out_ra_a_q;
  assign out_ra_b     = out_ra_b_q;
  assign out_ra_m     = out_ra_m_q;
  assign out_ra_d     = out_ra_d_q;
  assign out_is_mem   = out_is_mem_q;
  assign stall_cnt    = stall_cnt_q;
  assign dbg_state    = state_q;
  assign dbg_pending  = pending_q;
  assign dbg_mem_busy = mem_busy_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hand-computed expectations for hazard
// stalls, memory-op serialisation, set-over-clear, flush rollback, streaming
// and asynchronous reset.
module tb_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ra_a, ra_b, ra_m, ra_d;
  logic        is_mem;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ra_a, out_ra_b, out_ra_m, out_ra_d;
  logic        out_is_mem;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        mem_done;
  logic        flush;
  logic [15:0] stall_cnt;
  logic        dbg_state;
  logic [15:0] dbg_pending;
  logic        dbg_mem_busy;

  int checks;
  int errors;

  issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ra_a        (ra_a),
    .ra_b        (ra_b),
    .ra_m        (ra_m),
    .ra_d        (ra_d),
    .is_mem      (is_mem),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ra_a    (out_ra_a),
    .out_ra_b    (out_ra_b),
    .out_ra_m    (out_ra_m),
    .out_ra_d    (out_ra_d),
    .out_is_mem  (out_is_mem),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .mem_done    (mem_done),
    .flush       (flush),
    .stall_cnt   (stall_cnt),
    .dbg_state   (dbg_state),
    .dbg_pending (dbg_pending),
    .dbg_mem_busy(dbg_mem_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    ra_a = 4'd0; ra_b = 4'd0; ra_m = 4'd0; ra_d = 4'd0;
    is_mem = 1'b0;
    wb_valid = 1'b0; wb_addr = 4'd0;
    mem_done = 1'b0;
    flush = 1'b0;
  endtask

  task automatic present(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                         input logic [3:0] d, input logic mem);
    in_valid = 1'b1;
    ra_a = a; ra_b = b; ra_m = m; ra_d = d;
    is_mem = mem;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_pending", 32'(dbg_pending), 32'd0);
    check("rst_mem_busy", 32'(dbg_mem_busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // RAW hazard on r3, released by a same-cycle writeback
    present(4'd0, 4'd0, 4'd0, 4'd3, 1'b0);
    out_ready = 1'b0;
    #1 check("raw_first_ready", 32'(in_ready), 32'd1);
    tick();
    check("raw_slot_valid", 32'(out_valid), 32'd1);
    check("raw_slot_rd", 32'(out_ra_d), 32'd3);
    check("raw_pending3", 32'(dbg_pending), 32'h0008);
    present(4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
    out_ready = 1'b1;
    #1 check("raw_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("raw_drained", 32'(out_valid), 32'd0);
    check("raw_stall1", 32'(stall_cnt), 32'd1);
    tick();
    check("raw_stall2", 32'(stall_cnt), 32'd2);
    wb_valid = 1'b1; wb_addr = 4'd3;
    #1 check("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    check("raw_accept_valid", 32'(out_valid), 32'd1);
    check("raw_accept_ra", 32'(out_ra_a), 32'd3);
    check("raw_pending_clr", 32'(dbg_pending), 32'd0);
    check("raw_stall_hold", 32'(stall_cnt), 32'd2);
    idle_inputs();
    tick();

    // Memory ops serialise; accept in the mem_done cycle keeps mem_busy
    present(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    #1 check("mem_first_ready", 32'(in_ready), 32'd1);
    tick();
    check("mem_busy_set", 32'(dbg_mem_busy), 32'd1);
    check("mem_slot_is_mem", 32'(out_is_mem), 32'd1);
    #1 check("mem_second_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("mem_stall4", 32'(stall_cnt), 32'd4);
    mem_done = 1'b1;
    #1 check("mem_done_ready", 32'(in_ready), 32'd1);
    tick();
    check("mem_busy_kept", 32'(dbg_mem_busy), 32'd1);
    check("mem_accept_valid", 32'(out_valid), 32'd1);
    check("mem_stall_hold", 32'(stall_cnt), 32'd4);
    idle_inputs();
    mem_done = 1'b1;
    tick();
    check("mem_busy_clr", 32'(dbg_mem_busy), 32'd0);
    mem_done = 1'b0;
    tick();

    // Set wins over same-cycle clear
    present(4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    wb_valid = 1'b1; wb_addr = 4'd5;
    tick();
    check("setclr_pending5", 32'(dbg_pending), 32'h0020);
    idle_inputs();
    wb_valid = 1'b1; wb_addr = 4'd5;
    tick();
    check("setclr_cleared", 32'(dbg_pending), 32'd0);
    // Writeback to a register that is not pending changes nothing
    wb_addr = 4'd11;
    tick();
    check("wb_not_pending", 32'(dbg_pending), 32'd0);
    idle_inputs();
    tick();

    // Flush of an unissued slot rolls back its destination
    out_ready = 1'b0;
    present(4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
    tick();
    check("flush_pre_pending", 32'(dbg_pending), 32'h0080);
    present(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    flush = 1'b1;
    #1 check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_pending", 32'(dbg_pending), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    idle_inputs();

    // Flush of a slot that drains the same cycle counts as issued
    present(4'd0, 4'd0, 4'd0, 4'd9, 1'b0);
    tick();
    idle_inputs();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    check("flushdrain_valid", 32'(out_valid), 32'd0);
    check("flushdrain_pending", 32'(dbg_pending), 32'h0200);
    idle_inputs();
    wb_valid = 1'b1; wb_addr = 4'd9;
    tick();
    idle_inputs();

    // Back-to-back stream with no dependencies
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      present(4'd0, 4'(i), 4'(15 - i), 4'd0, 1'b0);
      #1 check("stream_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ra_b", 32'(out_ra_b), 32'(i));
      check("stream_ra_m", 32'(out_ra_m), 32'(15 - i));
    end
    check("stream_pending", 32'(dbg_pending), 32'd0);
    check("stream_no_stall", 32'(stall_cnt), 32'd4);
    idle_inputs();
    tick();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    present(4'd0, 4'd0, 4'd0, 4'd2, 1'b1);
    tick();
    present(4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_stall", 32'(stall_cnt), 32'd9);
    check("pre_rst_pending", 32'(dbg_pending), 32'h0004);
    check("pre_rst_busy", 32'(dbg_mem_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_stall", 32'(stall_cnt), 32'd0);
    check("async_pending", 32'(dbg_pending), 32'd0);
    check("async_busy", 32'(dbg_mem_busy), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_rd", 32'(out_ra_d), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
